// File: rtl/ftdi_ser_ctrl.sv
// rtl/ftdi_ser_ctrl.sv - FTDI synchronous serial link sequencer (optional parity: FTDI_SER_PARITY_EN)
module ftdi_ser_ctrl #(
  parameter int CDiv    = 4,
  parameter int CBitCnt = 8
) (
  input  logic       AClkH,
  input  logic       AResetHN,
  input  logic       AClkHEn,
  input  logic [7:0] ATxData,
  input  logic       ATxValid,
  output logic       ATxReady,
  input  logic       ASerI,
  output logic       ASerO,
  output logic       ASerClk,
  output logic       AShiftStb,
  output logic       ALoadStb,
  output logic [7:0] ARxData,
  output logic       ARxValid,
  output logic       ARxPErr,
  output logic       ABusy
);

`ifdef FTDI_SER_PARITY_EN
  localparam int CFrameBits = CBitCnt + 1;
`else
  localparam int CFrameBits = CBitCnt;
`endif

  typedef enum logic [1:0] {StIdle, StShift, StLoad} stateT;

  stateT                 state, stateNxt;
  logic [7:0]            divCnt;
  logic                  serClk;
  logic [3:0]            bitCnt;
  logic [CFrameBits-1:0] txSr;
  logic [CFrameBits-1:0] rxSr;
  logic                  serO;
  logic [7:0]            rxData;
  logic                  rxPErr;

  logic divEnd, riseEv, fallEv, lastFall;

  assign divEnd   = (divCnt == 8'(CDiv - 1));
  assign riseEv   = (state == StShift) && divEnd && !serClk;
  assign fallEv   = (state == StShift) && divEnd && serClk;
  assign lastFall = fallEv && (bitCnt == 4'(CFrameBits));

  always_ff @(posedge AClkH) begin
    if (!AResetHN) state <= StIdle;
    else if (AClkHEn) state <= stateNxt;
  end

  always_comb begin
    stateNxt  = state;
    ATxReady  = 1'b0;
    ABusy     = 1'b1;
    AShiftStb = 1'b0;
    ALoadStb  = 1'b0;
    ARxValid  = 1'b0;
    case (state)
      StIdle: begin
        ATxReady = 1'b1;
        ABusy    = 1'b0;
        if (ATxValid) stateNxt = StShift;
      end
      StShift: begin
        AShiftStb = riseEv && AClkHEn;
        if (lastFall) stateNxt = StLoad;
      end
      StLoad: begin
        ALoadStb = AClkHEn;
        ARxValid = AClkHEn;
        stateNxt = StIdle;
      end
      default: stateNxt = StIdle;
    endcase
  end

  always_ff @(posedge AClkH) begin
    if (!AResetHN) begin
      divCnt <= '0;
      serClk <= 1'b0;
      bitCnt <= '0;
      txSr   <= '0;
      rxSr   <= '0;
      serO   <= 1'b0;
      rxData <= '0;
      rxPErr <= 1'b0;
    end else if (AClkHEn) begin
      case (state)
        StIdle: begin
          if (ATxValid) begin
`ifdef FTDI_SER_PARITY_EN
            txSr <= {ATxData, ^ATxData};
`else
            txSr <= ATxData;
`endif
            serO   <= ATxData[7];
            divCnt <= '0;
            serClk <= 1'b0;
            bitCnt <= '0;
            rxSr   <= '0;
          end
        end
        StShift: begin
          if (divEnd) begin
            divCnt <= '0;
            serClk <= ~serClk;
          end else begin
            divCnt <= divCnt + 8'd1;
          end
          if (riseEv) begin
            rxSr   <= {rxSr[CFrameBits-2:0], ASerI};
            bitCnt <= bitCnt + 4'd1;
          end
          if (fallEv) begin
            txSr <= {txSr[CFrameBits-2:0], 1'b0};
            serO <= txSr[CFrameBits-2];
          end
          // Capture on the final falling edge so the byte is already stable during the LOAD cycle.
          if (lastFall) begin
`ifdef FTDI_SER_PARITY_EN
            rxData <= rxSr[CFrameBits-1:1];
            rxPErr <= ^rxSr;
`else
            rxData <= rxSr;
            rxPErr <= 1'b0;
`endif
          end
        end
        StLoad: serO <= 1'b0;
        default: ;
      endcase
    end
  end

  assign ASerO   = serO;
  assign ASerClk = serClk;
  assign ARxData = rxData;
  assign ARxPErr = rxPErr;

endmodule

// File: doc/ftdi_ser_ctrl.md
Name: ftdi_ser_ctrl

Overview:
- Single-clock sequencer for the FTDI synchronous serial link.
- Generates the serial bit clock from AClkH and shifts one Tx byte out MSB-first while sampling the Rx line.
- Emits shift/load strobes so an external shift-register/latch decoder pair can run on one clock with enables.
- Presents the received byte on a valid pulse; Tx byte accepted through a valid/ready handshake.

Parameters:
- CDiv, 4, half-period of ASerClk in AClkH cycles; legal range 1..255.
- CBitCnt, 8, data bits per frame; fixed at 8 for this revision.

Ports:
- AClkH  in  1  system clock; all flops rise on it.
- AResetHN  in  1  reset, synchronous, active-low.
- AClkHEn  in  1  global clock enable; low freezes all state.
- ATxData  in  8  byte to transmit.
- ATxValid  in  1  Tx byte offered.
- ATxReady  out  1  block idle, can accept ATxData.
- ASerI  in  1  serial Rx line.
- ASerO  out  1  serial Tx line.
- ASerClk  out  1  generated serial clock.
- AShiftStb  out  1  one-cycle strobe; the external shift register captures ASerI.
- ALoadStb  out  1  one-cycle strobe; the external parallel latch loads.
- ARxData  out  8  received byte.
- ARxValid  out  1  one-cycle pulse; ARxData is new.
- ARxPErr  out  1  parity error for the current ARxData (see Optional Feature).
- ABusy  out  1  frame in progress.

Behaviour:
- Reset (AResetHN low at an AClkH edge): state IDLE, ASerClk=0, ASerO=0, ATxReady=1, ARxData=0, ARxValid=0, ARxPErr=0, AShiftStb=0, ALoadStb=0, ABusy=0, divider and bit counters 0. Reset mid-frame aborts the frame; no ARxValid is produced.
- AClkHEn=0: every register holds its value. AShiftStb, ALoadStb and ARxValid are forced to 0 during that cycle. A pending strobe fires on the first enabled cycle.
- States: IDLE -> SHIFT -> LOAD -> IDLE.
- IDLE: ATxReady=1. Accept occurs when ATxValid=1, ATxReady=1 and AClkHEn=1. On accept: latch ATxData into the Tx shift register, set ASerO=ATxData[7], ATxReady=0, ABusy=1, next state SHIFT.
- SHIFT:
  - Divider counts 0..CDiv-1; ASerClk toggles when the count reaches CDiv-1, then the count returns to 0.
  - Rising ASerClk edges: AShiftStb=1 on the same cycle, ASerI is sampled into the Rx register as {rx[6:0], ASerI}, and the bit counter increments.
  - Falling edges: the Tx register shifts left; ASerO takes the next bit.
  - After the falling edge that follows the 8th rising edge, next state is LOAD. ASerClk ends low.
  - SHIFT lasts exactly 16*CDiv cycles.
- LOAD (1 cycle): ALoadStb=1, ARxValid=1, ARxData<=rx register, ASerO<=0. Next state IDLE with ATxReady=1 and ABusy=0 from the following cycle.
- Latency with the accept in cycle 0: ARxValid in cycle 16*CDiv+1. Earliest next accept is in cycle 16*CDiv+2, so there is no back-to-back overlap.
- ATxValid is ignored outside IDLE. ATxData changes after accept do not affect the frame in flight.
- No Rx backpressure: ARxData holds until the next LOAD.
- CDiv=1 is legal: ASerClk period is 2 cycles, and each AShiftStb is 2 cycles apart.

Optional Feature:
- Macro: FTDI_SER_PARITY_EN.
- Defined:
  - A 9th bit, even parity of ATxData, is sent after the LSB; a 9th Rx bit is sampled.
  - SHIFT lasts 18*CDiv cycles; the 9th AShiftStb is still emitted.
  - In LOAD, ARxPErr = XOR of the 8 received data bits and the received parity bit. It holds until the next LOAD.
  - The parity bit is not shifted into ARxData.
- Undefined: 8-bit frames only, ARxPErr tied 0, port kept.

Test Plan:
- Reset then idle, CDiv=4: hold ATxValid=0 for 100 cycles -> ATxReady=1, ASerClk=0, ASerO=0, no strobes.
- ATxData=0xA5, ASerI looped to ASerO, CDiv=4: accept at cycle 0 -> 8 AShiftStb pulses 8 cycles apart, the first at cycle 4; ARxValid and ALoadStb at cycle 65 with ARxData=0xA5; ATxReady=1 at cycle 66.
- CDiv=1, ATxData=0x3C, ASerI tied 1 -> ARxValid at cycle 17, ARxData=0xFF, ASerO bit sequence 0,0,1,1,1,1,0,0.
- AClkHEn low for 10 cycles mid-SHIFT -> ASerClk, ASerO and counters frozen; ARxValid delayed by exactly 10 cycles; data unchanged.
- AResetHN low for 1 cycle after the 3rd AShiftStb -> IDLE next cycle; no ARxValid; a new frame with 0x5A completes correctly.
- FTDI_SER_PARITY_EN, loopback 0x07: ARxValid at 18*CDiv+1 with ARxPErr=0. Force the Rx parity bit inverted -> ARxPErr=1, ARxData still 0x07.
